dmem_responder: RTL

- Multi-cycle data-memory responder: the target end of the core's memRead/memWrite data-memory interface.
- Captures one load/store request and holds the core with `stall` for a configurable number of wait states.
- Completes the access and pulses `ready` for exactly one cycle.
- Sits between the datapath's memory port and on-chip RAM; replaces the zero-latency combinational data memory.

---
 rtl/dmem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target that stalls the core for WAIT_CYC wait states, then pulses ready.
// Optional access counters (rdCount/wrCount) are built when DMEM_ACCESS_CNT_EN is defined.
module dmem_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              ready,
  output logic              stall
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rdCount,
  output logic [15:0]       wrCount
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic wr_q, wr_d;
  logic req;
  logic [DATA_W-1:0] mem_q [DEPTH];
  assign req    = memRead | memWrite;
  assign stall  = (state_q == WAIT) | ((state_q == IDLE) & req & ~rst);
  assign ready  = state_q == DONE;
  assign rdData = rd_data_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    if (state_q == IDLE && req) begin
      addr_d  = addr;
      data_d  = wrData;
      wr_d    = memWrite;
      cnt_d   = CNT_INIT;
      state_d = (WAIT_CYC > 0) ? WAIT : DONE;
    end else if (state_q == WAIT) begin
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      state_d = (cnt_q == 4'd0) ? DONE : WAIT;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
    // load data is captured on the edge that enters DONE, so it is valid for the whole ready cycle
    if (state_d == DONE && state_q != DONE && !wr_d) rd_data_d = mem_q[addr_d];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
    end
  end
  // stores commit on the edge leaving DONE; a reset during WAIT/DONE drops them
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == DONE && wr_q) begin
      mem_q[addr_q] <= data_q;
    end
  end
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  always_comb begin
    rd_cnt_d = (ready && !wr_q && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    wr_cnt_d = (ready &&  wr_q && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign rdCount = rd_cnt_q;
  assign wrCount = wr_cnt_q;
`endif
endmodule
